// File: rtl/riscv_ctrl_pkg.sv
// Shared RISC-V control definitions: opcodes, funct fields, writeback sources,
// CSR ops and the control bundle carried down the pipeline.
package riscv_ctrl_pkg;

  localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
  localparam logic [6:0] OPCODE_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPCODE_OP       = 7'b0110011;
  localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
  localparam logic [6:0] OPCODE_JAL      = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
  localparam logic [6:0] OPCODE_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPCODE_CUSTOM_0 = 7'b0001011;

  localparam logic [2:0] F3_SLLI    = 3'b001;
  localparam logic [2:0] F3_SRLI    = 3'b101;
  localparam logic [2:0] F3_LD      = 3'b011;
  localparam logic [2:0] F3_LWU     = 3'b110;
  localparam logic [2:0] F3_LDU     = 3'b111;
  localparam logic [2:0] F3_SD      = 3'b011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] SRC_ALU    = 3'b000;
  localparam logic [2:0] SRC_DMEM   = 3'b001;
  localparam logic [2:0] SRC_PC4    = 3'b010;
  localparam logic [2:0] SRC_IMM    = 3'b011;
  localparam logic [2:0] SRC_CSR    = 3'b100;
  localparam logic [2:0] SRC_MUL    = 3'b101;
  localparam logic [2:0] SRC_CUSTOM = 3'b110;

  localparam logic [1:0] CSR_RW = 2'b00;
  localparam logic [1:0] CSR_RS = 2'b01;
  localparam logic [1:0] CSR_RC = 2'b10;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] d_size;
    logic       d_unsigned;
    logic [2:0] mem_to_reg;
    logic [1:0] csr_op;
    logic       csr_imm;
    logic       csr_write;
    logic       illegal;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [2:0] funct3;
  } ctrl_bundle_t;

  localparam int CTRL_W = $bits(ctrl_bundle_t);

endpackage

// File: rtl/ctrl_decoder.sv
// Purely combinational instruction decoder producing the control bundle.
// Illegal encodings carry only the illegal flag plus the raw rd/rs1/funct3 fields.
module ctrl_decoder
  import riscv_ctrl_pkg::*;
#(
  parameter bit EN_MUL     = 1'b0,
  parameter bit EN_CUSTOM0 = 1'b0
) (
  input  logic [31:0]  i_instr,
  output ctrl_bundle_t o_ctrl
);

  logic [6:0]   opcode;
  logic [6:0]   funct7;
  logic [2:0]   funct3;
  logic [4:0]   rd;
  logic [4:0]   rs1;
  logic         illegal;
  logic         unused_rs2;
  ctrl_bundle_t dec;

  assign opcode     = i_instr[6:0];
  assign rd         = i_instr[11:7];
  assign funct3     = i_instr[14:12];
  assign rs1        = i_instr[19:15];
  assign funct7     = i_instr[31:25];
  assign unused_rs2 = ^i_instr[24:20];

  always_comb begin
    dec        = '0;
    dec.rd     = rd;
    dec.rs1    = rs1;
    dec.funct3 = funct3;
    illegal    = 1'b0;
    case (opcode)
      OPCODE_OP: begin
        dec.reg_write  = 1'b1;
        dec.mem_to_reg = SRC_ALU;
        if (EN_MUL && funct7 == F7_MULDIV) dec.mem_to_reg = SRC_MUL;
        else if (funct7 != F7_BASE && funct7 != F7_ALT) illegal = 1'b1;
      end
      OPCODE_OP_IMM: begin
        dec.reg_write  = 1'b1;
        dec.mem_to_reg = SRC_ALU;
        if (funct3 == F3_SLLI && funct7 != F7_BASE) illegal = 1'b1;
        if (funct3 == F3_SRLI && funct7 != F7_BASE && funct7 != F7_ALT) illegal = 1'b1;
      end
      OPCODE_AUIPC: begin
        dec.reg_write  = 1'b1;
        dec.mem_to_reg = SRC_ALU;
      end
      OPCODE_LOAD: begin
        dec.reg_write  = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = SRC_DMEM;
        dec.d_size     = funct3[1:0];
        dec.d_unsigned = funct3[2];
        if (funct3 == F3_LD || funct3 == F3_LWU || funct3 == F3_LDU) illegal = 1'b1;
      end
      OPCODE_STORE: begin
        dec.mem_write = 1'b1;
        dec.d_size    = funct3[1:0];
        if (funct3 >= F3_SD) illegal = 1'b1;
      end
      OPCODE_JAL, OPCODE_JALR: begin
        dec.reg_write  = 1'b1;
        dec.mem_to_reg = SRC_PC4;
      end
      OPCODE_LUI: begin
        dec.reg_write  = 1'b1;
        dec.mem_to_reg = SRC_IMM;
      end
      OPCODE_SYSTEM: begin
        // funct3[2] selects the immediate form; funct3[1:0] selects RW/RS/RC
        dec.mem_to_reg = SRC_CSR;
        dec.csr_imm    = funct3[2];
        case (funct3[1:0])
          2'b01: begin
            dec.csr_op    = CSR_RW;
            dec.csr_write = 1'b1;
            dec.reg_write = (rd != 5'd0);
          end
          2'b10: begin
            dec.csr_op    = CSR_RS;
            dec.reg_write = 1'b1;
            dec.csr_write = (rs1 != 5'd0);
          end
          2'b11: begin
            dec.csr_op    = CSR_RC;
            dec.reg_write = 1'b1;
            dec.csr_write = (rs1 != 5'd0);
          end
          default: illegal = 1'b1;
        endcase
      end
      OPCODE_CUSTOM_0: begin
        if (EN_CUSTOM0) begin
          dec.reg_write  = 1'b1;
          dec.mem_to_reg = SRC_CUSTOM;
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      dec         = '0;
      dec.illegal = 1'b1;
      dec.rd      = rd;
      dec.rs1     = rs1;
      dec.funct3  = funct3;
    end
  end

  assign o_ctrl = dec;

endmodule

// File: rtl/pipelined_control_unit.sv
// Decode stage with an output register plus one skid entry; valid/ready handshake
// on both sides and a saturating count of illegal instructions delivered.
module pipelined_control_unit
  import riscv_ctrl_pkg::*;
#(
  parameter bit EN_MUL     = 1'b0,
  parameter bit EN_CUSTOM0 = 1'b0,
  parameter int CNT_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [31:0]      i_instr,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_ready,
  input  logic             i_flush,
  output logic             o_valid,
  output ctrl_bundle_t     o_ctrl,
  output logic [CNT_W-1:0] o_illegal_cnt
);

  // Handshake: an input beat moves on i_valid && o_ready, an output beat on
  // o_valid && i_ready; o_ready is the registered "skid entry empty" flag.
  ctrl_bundle_t     dec_ctrl;
  ctrl_bundle_t     out_ctrl;
  ctrl_bundle_t     skid_ctrl;
  logic             out_valid;
  logic             skid_empty;
  logic [CNT_W-1:0] cnt;
  logic             take_in;
  logic             take_out;

  ctrl_decoder #(
    .EN_MUL    (EN_MUL),
    .EN_CUSTOM0(EN_CUSTOM0)
  ) u_decoder (
    .i_instr(i_instr),
    .o_ctrl (dec_ctrl)
  );

  assign take_in  = i_valid && skid_empty;
  assign take_out = out_valid && i_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      out_valid  <= 1'b0;
      out_ctrl   <= '0;
      skid_empty <= 1'b1;
      skid_ctrl  <= '0;
      cnt        <= '0;
    end else begin
      if (take_out && out_ctrl.illegal && cnt != {CNT_W{1'b1}}) cnt <= cnt + CNT_W'(1);
      if (i_flush) begin
        out_valid  <= 1'b0;
        skid_empty <= 1'b1;
      end else if (!out_valid || take_out) begin
        // Output register is free this cycle: skid entry first to keep order
        if (!skid_empty) begin
          out_ctrl   <= skid_ctrl;
          out_valid  <= 1'b1;
          skid_empty <= 1'b1;
        end else if (take_in) begin
          out_ctrl  <= dec_ctrl;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (take_in) begin
        skid_ctrl  <= dec_ctrl;
        skid_empty <= 1'b0;
      end
    end
  end

  assign o_ready       = skid_empty;
  assign o_valid       = out_valid;
  assign o_ctrl        = out_ctrl;
  assign o_illegal_cnt = cnt;

endmodule
